// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one data-memory bus between instruction fetch
// and the MEM stage. Each transaction runs IDLE -> BUSY -> DONE. Requests are
// granted MEM-first. A BUSY watchdog aborts hung transactions and sets a
// sticky error. stall_pipe holds the pipeline while any requester waits.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_pipe,
    output logic        timeout_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            owner_mem_q;  // 1: MEM stage owns the bus, 0: fetch
    logic [CW-1:0]   cnt_q;

    logic            grant_mem;
    logic            grant_if;
    logic            busy_timeout;
    logic            busy_end;

    // Grant and completion conditions shared by the FSM and the datapath
    always_comb begin
        grant_mem    = (state_q == S_IDLE) && mem_req;
        grant_if     = (state_q == S_IDLE) && !mem_req && if_req;
        busy_timeout = (state_q == S_BUSY) && !bus_ack && (cnt_q == CW'(TIMEOUT - 1));
        busy_end     = (state_q == S_BUSY) && (bus_ack || busy_timeout);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE never samples requests so a held req is not reissued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_mem || grant_if) state_d = S_BUSY;
            S_BUSY:  if (busy_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus drive, watchdog counter, result capture and completion pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_mem_q <= 1'b0;
            cnt_q       <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            if_ready    <= 1'b0;
            mem_ready   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_mem) begin
                owner_mem_q <= 1'b1;
                cnt_q       <= '0;
                bus_req     <= 1'b1;
                bus_we      <= mem_we;
                bus_addr    <= mem_addr;
                bus_wdata   <= mem_wdata;
            end else if (grant_if) begin
                owner_mem_q <= 1'b0;
                cnt_q       <= '0;
                bus_req     <= 1'b1;
                bus_we      <= 1'b0;
                bus_addr    <= if_addr;
                bus_wdata   <= '0;
            end else if (state_q == S_BUSY) begin
                cnt_q <= cnt_q + CW'(1);
            end

            if (busy_end) begin
                bus_req <= 1'b0;
                if (owner_mem_q) begin
                    mem_rdata <= bus_ack ? bus_rdata : '0;
                end else begin
                    if_rdata <= bus_ack ? bus_rdata : '0;
                end
            end

            if (busy_timeout) begin
                timeout_err <= 1'b1;
            end

            // Pulses are high exactly for the DONE cycle
            mem_ready <= busy_end && owner_mem_q;
            if_ready  <= busy_end && !owner_mem_q;
        end
    end

    assign stall_pipe = (mem_req && !mem_ready) || (if_req && !if_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with TIMEOUT=8.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_pipe;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ready    (if_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .stall_pipe  (stall_pipe),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        bus_rdata = '0; bus_ack = 1'b0;
        tick();
        tick();
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %0b exp 0", bus_req); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we got %0b exp 0", bus_we); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got %h exp 0", bus_addr); end
        checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata got %h exp 0", bus_wdata); end
        checks++; if (if_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got if=%0b mem=%0b exp 0 0", if_ready, mem_ready); end
        checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got if=%h mem=%h exp 0 0", if_rdata, mem_rdata); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %0b exp 0", timeout_err); end
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall_pipe); end
        rst = 1'b1;
        tick();
    endtask

    // Load with ack three cycles after bus_req rises; req held through ready cycle
    task automatic test_load();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0100;
        #1;
        checks++; if (stall_pipe !== 1'b1) begin errors++; $display("FAIL load_stall_pre got %0b exp 1", stall_pipe); end
        tick();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL load_bus_req got %0b exp 1", bus_req); end
        checks++; if (bus_addr !== 32'h0000_0100) begin errors++; $display("FAIL load_bus_addr got %h exp 00000100", bus_addr); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL load_bus_we got %0b exp 0", bus_we); end
        tick();
        tick();
        checks++; if (mem_ready !== 1'b0 || stall_pipe !== 1'b1) begin errors++; $display("FAIL load_wait got ready=%0b stall=%0b exp 0 1", mem_ready, stall_pipe); end
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %0b exp 1", mem_ready); end
        checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", mem_rdata); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL load_bus_req_drop got %0b exp 0", bus_req); end
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL load_stall_done got %0b exp 0", stall_pipe); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL load_if_ready got %0b exp 0", if_ready); end
        tick();
        // DONE guard: req still held across the DONE->IDLE edge, no reissue
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL done_guard_bus_req got %0b exp 0", bus_req); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL done_guard_ready got %0b exp 0", mem_ready); end
        checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata_hold got %h exp deadbeef", mem_rdata); end
        mem_req = 1'b0;
        tick();
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL done_guard_idle got %0b exp 0", bus_req); end
    endtask

    // Both requesters rise together: MEM first, IF after the DONE cycle
    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 32'h0000_0200;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0300;
        tick();
        checks++; if (bus_addr !== 32'h0000_0300) begin errors++; $display("FAIL simul_mem_first got %h exp 00000300", bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        bus_ack = 1'b0;
        checks++; if (mem_ready !== 1'b1 || if_ready !== 1'b0) begin errors++; $display("FAIL simul_mem_ready got mem=%0b if=%0b exp 1 0", mem_ready, if_ready); end
        checks++; if (stall_pipe !== 1'b1) begin errors++; $display("FAIL simul_if_stalled got %0b exp 1", stall_pipe); end
        tick();
        mem_req = 1'b0;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL simul_idle_gap got %0b exp 0", bus_req); end
        tick();
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0200) begin errors++; $display("FAIL simul_if_grant got req=%0b addr=%h exp 1 00000200", bus_req, bus_addr); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL simul_if_we got %0b exp 0", bus_we); end
        bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
        tick();
        bus_ack = 1'b0;
        checks++; if (if_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL simul_if_ready got if=%0b mem=%0b exp 1 0", if_ready, mem_ready); end
        checks++; if (if_rdata !== 32'h2222_2222) begin errors++; $display("FAIL simul_if_rdata got %h exp 22222222", if_rdata); end
        checks++; if (mem_rdata !== 32'h1111_1111) begin errors++; $display("FAIL simul_mem_rdata_hold got %h exp 11111111", mem_rdata); end
        tick();
        if_req = 1'b0;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL simul_if_ready_pulse got %0b exp 0", if_ready); end
        tick();
    endtask

    // Store acked on the first BUSY cycle
    task automatic test_store();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0400; mem_wdata = 32'h1234_5678;
        tick();
        checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL store_bus_we got %0b exp 1", bus_we); end
        checks++; if (bus_wdata !== 32'h1234_5678) begin errors++; $display("FAIL store_bus_wdata got %h exp 12345678", bus_wdata); end
        checks++; if (bus_addr !== 32'h0000_0400) begin errors++; $display("FAIL store_bus_addr got %h exp 00000400", bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
        tick();
        bus_ack = 1'b0;
        checks++; if (mem_ready !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL store_ready got ready=%0b req=%0b exp 1 0", mem_ready, bus_req); end
        tick();
        mem_req = 1'b0; mem_we = 1'b0;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL store_ready_pulse got %0b exp 0", mem_ready); end
        tick();
    endtask

    // Ack on the last permitted BUSY cycle wins; then a hung transaction times out
    task automatic test_timeout();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0500;
        tick();
        for (int i = 0; i < 7; i++) tick();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL ack8_still_busy got %0b exp 1", bus_req); end
        bus_ack = 1'b1; bus_rdata = 32'h0000_0077;
        tick();
        bus_ack = 1'b0;
        checks++; if (mem_ready !== 1'b1 || mem_rdata !== 32'h0000_0077) begin errors++; $display("FAIL ack8_result got ready=%0b rdata=%h exp 1 00000077", mem_ready, mem_rdata); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ack8_no_error got %0b exp 0", timeout_err); end
        tick();
        mem_req = 1'b0;
        tick();

        mem_req = 1'b1; mem_addr = 32'h0000_0600;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (bus_req !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_busy_%0d got req=%0b err=%0b exp 1 0", i, bus_req, timeout_err); end
        end
        tick();
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL timeout_bus_req got %0b exp 0", bus_req); end
        checks++; if (mem_ready !== 1'b1 || mem_rdata !== 32'h0) begin errors++; $display("FAIL timeout_result got ready=%0b rdata=%h exp 1 0", mem_ready, mem_rdata); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set got %0b exp 1", timeout_err); end
        tick();
        mem_req = 1'b0;
        tick();
        // Sticky across a later good transaction
        if_req = 1'b1; if_addr = 32'h0000_0700;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h0000_0042;
        tick();
        bus_ack = 1'b0;
        checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h0000_0042) begin errors++; $display("FAIL post_to_if got ready=%0b rdata=%h exp 1 00000042", if_ready, if_rdata); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky got %0b exp 1", timeout_err); end
        tick();
        if_req = 1'b0;
        tick();
    endtask

    // Asynchronous reset while BUSY
    task automatic test_reset_mid_busy();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0800;
        tick();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_granted got %0b exp 1", bus_req); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_bus_req got %0b exp 0", bus_req); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rstmid_err_clear got %0b exp 0", timeout_err); end
        mem_req = 1'b0;
        tick();
        rst = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_ready !== 1'b0 || if_ready !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_quiet_%0d got mem=%0b if=%0b req=%0b exp 0 0 0", i, mem_ready, if_ready, bus_req); end
        end
        bus_ack = 1'b0;
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", mem_rdata); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_simultaneous();
        test_store();
        test_timeout();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
